// File: rtl/dcache_line_adaptor.sv
// dcache_line_adaptor: bridges single-cycle 256-bit cache line transfers to
// 4-beat 64-bit memory bursts. One refill or writeback is in flight at a time.
//
// Handshake: the cache raises read_i/write_i with address_i (and line_i for a
// writeback) and holds them until resp_o. They are sampled only in IDLE.
// On the memory side, read_o/write_o stay high for the whole burst. Each
// cycle with resp_i=1 completes exactly one beat: it is either burst_i data
// accepted (read) or burst_o data taken (write). After the last beat, resp_o
// pulses for one cycle. All outputs come from registers or state only.
module dcache_line_adaptor #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_burst  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [s_line-1:0] line_i,
  output logic [s_line-1:0] line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i,
  output logic [1:0]        dbg_state_o
);

  localparam int num_beats = s_line / s_burst;
  localparam int cnt_w     = $clog2(num_beats);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);
  // Clears the line-offset bits so memory always sees a line-aligned address.
  localparam logic [31:0] addr_mask = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [cnt_w-1:0]  r_cnt;
  logic [cnt_w-1:0]  w_cnt_next;
  logic [s_line-1:0] r_line;
  logic [s_line-1:0] r_wbuf;
  logic [31:0]       r_addr;
  logic              w_start;
  logic              w_take;

  // Next-state logic: writeback wins over refill; each resp_i moves one beat.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_start      = 1'b0;
    w_take       = 1'b0;
    case (r_state)
      IDLE: begin
        if (write_i) begin
          w_state_next = WRITE;
          w_start      = 1'b1;
          w_cnt_next   = '0;
        end else if (read_i) begin
          w_state_next = READ;
          w_start      = 1'b1;
          w_cnt_next   = '0;
        end
      end
      READ, WRITE: begin
        if (resp_i) begin
          w_take     = 1'b1;
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt == last_beat) begin
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and beat counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Request capture and refill assembly; beat 0 lands in the low bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_wbuf <= '0;
      r_line <= '0;
    end else begin
      if (w_start) begin
        r_addr <= address_i & addr_mask;
        if (write_i) begin
          r_wbuf <= line_i;
        end
      end
      if (w_take && (r_state == READ)) begin
        r_line[int'(r_cnt) * s_burst +: s_burst] <= burst_i;
      end
    end
  end

  assign read_o      = (r_state == READ);
  assign write_o     = (r_state == WRITE);
  assign resp_o      = (r_state == DONE);
  assign burst_o     = (r_state == WRITE) ? r_wbuf[int'(r_cnt) * s_burst +: s_burst] : '0;
  assign address_o   = r_addr;
  assign line_o      = r_line;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_dcache_line_adaptor.sv
// Testbench for dcache_line_adaptor: reset behaviour, a table of directed
// transactions, reset mid-burst, stray strobes, then random transactions
// checked against a transaction-level model of the cache/memory exchange.
module tb_dcache_line_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;
  logic [1:0]   dbg_state_o;

  dcache_line_adaptor dut (
    .clk         (clk),
    .rst         (rst),
    .line_i      (line_i),
    .line_o      (line_o),
    .address_i   (address_i),
    .read_i      (read_i),
    .write_i     (write_i),
    .resp_o      (resp_o),
    .burst_i     (burst_i),
    .burst_o     (burst_o),
    .address_o   (address_o),
    .read_o      (read_o),
    .write_o     (write_o),
    .resp_i      (resp_i),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0]  exp_q[$];      // write beats still owed to memory, in order
  logic [255:0] model_line;    // last refill the cache should be seeing

  typedef struct {
    logic         wr;
    logic         rd;
    logic         hold_rd;     // keep read_i high after this transaction
    logic [31:0]  addr;
    logic [255:0] line;        // writeback data
    logic [255:0] beats;       // memory read data, beat k at [k*64 +: 64]
    logic [15:0]  waits;       // idle cycles before beat k at [k*4 +: 4]
    logic [31:0]  exp_addr;
    logic [255:0] exp_line;    // expected refill result
    int           exp_cycles;  // cycles read_o/write_o should be high
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Checks made on every cycle of an active burst.
  task automatic check_busy(input vec_t v, inout int act_cnt);
    if (read_o || write_o) act_cnt++;
    check("busy_write_o", 256'(write_o), 256'(v.wr));
    check("busy_read_o", 256'(read_o), 256'(!v.wr && v.rd));
    check("busy_resp_o", 256'(resp_o), 256'(0));
    if (v.wr) begin
      if (exp_q.size() > 0) check("burst_o", 256'(burst_o), 256'(exp_q[0]));
      else check("burst_o_extra", 256'(write_o), 256'(0));
    end
  endtask

  // Drives one full cache transaction; starts and ends in an IDLE cycle.
  task automatic run_txn(input vec_t v);
    int act_cnt;
    act_cnt = 0;
    exp_q.delete();
    if (v.wr) for (int k = 0; k < 4; k++) exp_q.push_back(v.line[k*64 +: 64]);
    write_i   = v.wr;
    read_i    = v.rd;
    address_i = v.addr;
    line_i    = v.line;
    resp_i    = 1'b0;
    step();
    check("address_o", 256'(address_o), 256'(v.exp_addr));
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < int'(v.waits[k*4 +: 4]); w++) begin
        resp_i  = 1'b0;
        burst_i = rand64();
        check_busy(v, act_cnt);
        step();
      end
      resp_i  = 1'b1;
      burst_i = v.beats[k*64 +: 64];
      check_busy(v, act_cnt);
      if (v.wr && exp_q.size() > 0) void'(exp_q.pop_front());
      step();
    end
    // DONE cycle: stray strobe from memory must be ignored.
    resp_i  = 1'($urandom_range(0, 1));
    burst_i = rand64();
    if (!v.wr && v.rd) model_line = v.exp_line;
    check("done_resp_o", 256'(resp_o), 256'(1));
    check("done_read_o", 256'(read_o), 256'(0));
    check("done_write_o", 256'(write_o), 256'(0));
    check("done_line_o", line_o, model_line);
    step();
    // IDLE cycle: cache drops its request now.
    write_i = 1'b0;
    read_i  = v.hold_rd;
    resp_i  = 1'($urandom_range(0, 1));
    check("idle_resp_o", 256'(resp_o), 256'(0));
    check("idle_state", 256'(dbg_state_o), 256'(0));
    check("idle_line_o", line_o, model_line);
    check("busy_cycles", 256'(act_cnt), 256'(v.exp_cycles));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t rv;
    int   kind;
    int   wsum;

    rst = 1'b0; read_i = 1'b1; write_i = 1'b0; resp_i = 1'b0;
    address_i = 32'h0000_0000; line_i = '0; burst_i = '0;
    model_line = '0;

    // Reset held with a live request and toggling strobe.
    for (int i = 0; i < 4; i++) begin
      resp_i  = ~resp_i;
      burst_i = rand64();
      step();
      check("rst_state", 256'(dbg_state_o), 256'(0));
      check("rst_outs", {read_o, write_o, resp_o, address_o, burst_o}, 256'(0));
      check("rst_line_o", line_o, 256'(0));
    end

    // Release: read_i sampled at the next edge, read_o one cycle later.
    resp_i    = 1'b0;
    address_i = 32'h1234_5678;
    rst       = 1'b1;
    step();
    check("rel_read_o", 256'(read_o), 256'(1));
    check("rel_address_o", 256'(address_o), 256'(32'h1234_5660));
    resp_i = 1'b1; burst_i = 64'hA5A5_0000_0000_0001;
    step();
    burst_i = 64'hA5A5_0000_0000_0002;
    step();
    check("mid_line_lo", 256'(line_o[127:0]), 256'({64'hA5A5_0000_0000_0002, 64'hA5A5_0000_0000_0001}));
    // Reset mid-read after two beats: immediate abort, no response.
    resp_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("abort_read_o", 256'(read_o), 256'(0));
    check("abort_resp_o", 256'(resp_o), 256'(0));
    check("abort_line_o", line_o, 256'(0));
    check("abort_state", 256'(dbg_state_o), 256'(0));
    read_i = 1'b0;
    step();
    rst = 1'b1;
    // Stray strobes in IDLE: nothing moves.
    for (int i = 0; i < 3; i++) begin
      resp_i  = 1'b1;
      burst_i = rand64();
      step();
      check("stray_state", 256'(dbg_state_o), 256'(0));
      check("stray_outs", {read_o, write_o, resp_o}, 256'(0));
      check("stray_line_o", line_o, model_line);
    end

    // Directed table.
    vecs[0] = '{wr: 1'b0, rd: 1'b1, hold_rd: 1'b0, addr: 32'h0000_1234, line: '0,
                beats: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                waits: 16'h0000, exp_addr: 32'h0000_1220,
                exp_line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                exp_cycles: 4};
    vecs[1] = '{wr: 1'b1, rd: 1'b0, hold_rd: 1'b0, addr: 32'hABCD_EF5F,
                line: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                beats: '0, waits: 16'h2220, exp_addr: 32'hABCD_EF40,
                exp_line: '0, exp_cycles: 10};
    vecs[2] = '{wr: 1'b1, rd: 1'b1, hold_rd: 1'b1, addr: 32'h8000_001F,
                line: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                       64'h0F0F_0F0F_F0F0_F0F0, 64'h5555_AAAA_5555_AAAA},
                beats: '0, waits: 16'h0101, exp_addr: 32'h8000_0000,
                exp_line: '0, exp_cycles: 6};
    vecs[3] = '{wr: 1'b0, rd: 1'b1, hold_rd: 1'b0, addr: 32'h8000_001F, line: '0,
                beats: {64'h8888_0000_0000_0004, 64'h8888_0000_0000_0003,
                        64'h8888_0000_0000_0002, 64'h8888_0000_0000_0001},
                waits: 16'h3000, exp_addr: 32'h8000_0000,
                exp_line: {64'h8888_0000_0000_0004, 64'h8888_0000_0000_0003,
                           64'h8888_0000_0000_0002, 64'h8888_0000_0000_0001},
                exp_cycles: 7};
    for (int i = 0; i < 4; i++) run_txn(vecs[i]);

    // Randomized transactions against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      kind       = $urandom_range(0, 2);
      rv.wr      = (kind != 0);
      rv.rd      = (kind != 1);
      rv.hold_rd = 1'b0;
      rv.addr    = $urandom;
      rv.line    = rand256();
      rv.beats   = rand256();
      wsum       = 0;
      for (int k = 0; k < 4; k++) begin
        rv.waits[k*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
        wsum += int'(rv.waits[k*4 +: 4]);
      end
      rv.exp_addr   = {rv.addr[31:5], 5'b0};
      rv.exp_line   = rv.beats;
      rv.exp_cycles = 4 + wsum;
      run_txn(rv);
      if ($urandom_range(0, 3) == 0) begin
        resp_i = 1'b1;
        step();
        check("rand_idle_state", 256'(dbg_state_o), 256'(0));
        check("rand_idle_line", line_o, model_line);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
